// File: rtl/score_player.sv
// Melody sequencer: walks a synchronous score ROM, holds each note code for
// its programmed number of beats, inserts a rest after every note, and
// reports the natural end of the score with a one-cycle done pulse.
module score_player #(
    parameter int BEAT_DIV = 25000000,
    parameter int GAP_CYC  = 2000000,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [4:0]        note,
    output logic              playing,
    output logic              done
);

    localparam int TICK_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [4:0]          note_q, note_d;
    logic [2:0]          beat_q, beat_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic [2:0] dur;
    logic       tick_wrap;
    logic       note_end;
    logic       loop_restart;

    assign dur          = rom_data[2:0];
    assign tick_wrap    = (tick_q == TICK_LAST);
    assign note_end     = tick_wrap && (beat_q == 3'd1);
    // An end marker at address 0 never loops, so an empty score cannot spin forever.
    assign loop_restart = loop_en && (rom_addr_q != '0);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            note_q     <= '0;
            beat_q     <= '0;
            tick_q     <= '0;
            gap_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            beat_q     <= beat_d;
            tick_q     <= tick_d;
            gap_q      <= gap_d;
        end
    end

    // Next-state selection; stop overrides everything, including start.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start) state_d = S_FETCH;
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (dur != 3'd0)       state_d = S_PLAY;
                    else if (loop_restart) state_d = S_FETCH;
                    else                   state_d = S_IDLE;
                end
                S_PLAY: begin
                    if (note_end) state_d = (GAP_CYC == 0) ? S_FETCH : S_GAP;
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath updates: address walk, note latch, beat/tick/gap counters.
    always_comb begin
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        beat_d     = beat_q;
        tick_d     = tick_q;
        gap_d      = gap_q;
        if (stop) begin
            rom_addr_d = '0;
            note_d     = '0;
            beat_d     = '0;
            tick_d     = '0;
            gap_d      = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    note_d = '0;
                    if (start) rom_addr_d = '0;
                end
                S_LOAD: begin
                    if (dur != 3'd0) begin
                        note_d = rom_data[7:3];
                        beat_d = dur;
                        tick_d = '0;
                    end else if (loop_restart) begin
                        rom_addr_d = '0;
                    end
                end
                S_PLAY: begin
                    tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                    if (tick_wrap) beat_d = beat_q - 3'd1;
                    if (note_end) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        note_d     = '0;
                        gap_d      = '0;
                    end
                end
                S_GAP:   gap_d = gap_q + GAP_W'(1);
                default: ;
            endcase
        end
    end

    // Outputs: done marks the LOAD cycle that ends the score without looping.
    always_comb begin
        playing = (state_q != S_IDLE);
        done    = (state_q == S_LOAD) && !stop && (dur == 3'd0) && !loop_restart;
    end

    assign rom_addr = rom_addr_q;
    assign note     = note_q;

endmodule
